// File: rtl/coin_credit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_credit_pkg
// Description : Shared types and constants for the coin credit collector:
//               FSM state encoding, coin-type encodings, coin values and the
//               valid item-code range.
// Revision    : 1.0 - initial release
// ============================================================================
package coin_credit_pkg;

    localparam int c_CREDIT_W = 8;
    localparam int c_ITEM_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CREDIT  = 2'd1,
        ST_REQUEST = 2'd2,
        ST_REFUND  = 2'd3
    } state_e;

    localparam logic [1:0] c_COIN_5  = 2'b00;
    localparam logic [1:0] c_COIN_10 = 2'b01;
    localparam logic [1:0] c_COIN_20 = 2'b10;
    localparam logic [1:0] c_COIN_50 = 2'b11;

    localparam logic [c_CREDIT_W-1:0] c_VAL_5  = 8'd5;
    localparam logic [c_CREDIT_W-1:0] c_VAL_10 = 8'd10;
    localparam logic [c_CREDIT_W-1:0] c_VAL_20 = 8'd20;
    localparam logic [c_CREDIT_W-1:0] c_VAL_50 = 8'd50;

    localparam logic [c_ITEM_W-1:0] c_ITEM_MIN = 4'd1;
    localparam logic [c_ITEM_W-1:0] c_ITEM_MAX = 4'd10;

    function automatic logic [c_CREDIT_W-1:0] coin_value(input logic [1:0] coin_type);
        logic [c_CREDIT_W-1:0] v;
        v = c_VAL_5;
        case (coin_type)
            c_COIN_5:  v = c_VAL_5;
            c_COIN_10: v = c_VAL_10;
            c_COIN_20: v = c_VAL_20;
            c_COIN_50: v = c_VAL_50;
            default:   v = c_VAL_5;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_credit_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : coin_credit_collector_if
// Description : Customer/vend-stage signal bundle for coin_credit_collector.
//               master: drives coin, keypad, cancel and vend-ack inputs.
//               slave : the collector; drives credit, selection, vend request,
//                       coin reject and refund outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface coin_credit_collector_if;
    import coin_credit_pkg::*;

    logic                  coin_valid;
    logic [1:0]            coin_type;
    logic                  key_valid;
    logic [c_ITEM_W-1:0]   key_code;
    logic                  cancel;
    logic                  vend_ack;
    logic [c_CREDIT_W-1:0] vend_balance;
    logic [c_CREDIT_W-1:0] deposited_amount;
    logic [c_ITEM_W-1:0]   item_code;
    logic                  vend_req;
    logic                  coin_reject;
    logic                  refund_valid;
    logic [c_CREDIT_W-1:0] refund_amount;

    modport master (
        output coin_valid, coin_type, key_valid, key_code, cancel, vend_ack, vend_balance,
        input  deposited_amount, item_code, vend_req, coin_reject, refund_valid, refund_amount
    );

    modport slave (
        input  coin_valid, coin_type, key_valid, key_code, cancel, vend_ack, vend_balance,
        output deposited_amount, item_code, vend_req, coin_reject, refund_valid, refund_amount
    );

endinterface
`default_nettype wire

// File: rtl/credit_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : credit_timeout_timer
// Description : Inactivity counter. Counts enabled cycles since the last
//               clear; expired is high on the cycle that completes
//               TIMEOUT_CYCLES idle cycles.
//   clk, reset : clock / asynchronous active-high reset
//   clear      : restart the count from zero
//   enable     : count this cycle
//   expired    : limit reached (qualified by enable)
// Revision    : 1.0 - initial release
// ============================================================================
module credit_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Expiry is flagged during the last idle cycle so the refund lands exactly
    // TIMEOUT_CYCLES cycles after the credit was last topped up.
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LAST)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/coin_credit_collector.sv
`default_nettype none
// ============================================================================
// Module      : coin_credit_collector
// Description : Vending-machine front end. Accumulates coin credit, latches a
//               keypad selection, hands both to the vend stage, and issues a
//               one-cycle refund of either the vend-stage change or the
//               cancelled credit.
//   clk, reset : clock / asynchronous active-high reset
//   bus        : coin_credit_collector_if.slave (coin, keypad, cancel,
//                vend handshake, reject and refund outputs)
// Build option: COIN_CREDIT_TIMEOUT_EN adds an inactivity auto-refund in
//               CREDIT after TIMEOUT_CYCLES cycles without an accepted coin.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_credit_collector
    import coin_credit_pkg::*;
#(
    parameter logic [7:0] MAX_CREDIT     = 8'd250,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    coin_credit_collector_if.slave  bus
);

    state_e                r_state, w_state_nxt;
    logic [c_CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [c_ITEM_W-1:0]   r_item, w_item_nxt;
    logic                  r_coin_reject, w_coin_reject_nxt;
    logic [c_CREDIT_W-1:0] r_refund_amount, w_refund_amount_nxt;

    logic [c_CREDIT_W:0]   w_sum;
    logic                  w_coin_fits;
    logic                  w_key_ok;
    logic                  w_timeout_expired;

    // Sum carried one bit wider so 250+50 cannot wrap into an acceptable value.
    assign w_sum       = {1'b0, r_credit} + {1'b0, coin_value(bus.coin_type)};
    assign w_coin_fits = (w_sum <= {1'b0, MAX_CREDIT});
    assign w_key_ok    = bus.key_valid && (bus.key_code >= c_ITEM_MIN) &&
                         (bus.key_code <= c_ITEM_MAX);

`ifdef COIN_CREDIT_TIMEOUT_EN
    logic w_timer_clear;

    // Any accepted coin changes the credit, so a credit change restarts the
    // idle count; outside CREDIT the counter is held at zero.
    assign w_timer_clear = (r_state != ST_CREDIT) || (w_credit_nxt != r_credit);

    credit_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .enable  (r_state == ST_CREDIT),
        .expired (w_timeout_expired)
    );
`else
    assign w_timeout_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_credit        <= '0;
            r_item          <= '0;
            r_coin_reject   <= 1'b0;
            r_refund_amount <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_credit        <= w_credit_nxt;
            r_item          <= w_item_nxt;
            r_coin_reject   <= w_coin_reject_nxt;
            r_refund_amount <= w_refund_amount_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_credit_nxt        = r_credit;
        w_item_nxt          = r_item;
        w_coin_reject_nxt   = 1'b0;
        w_refund_amount_nxt = r_refund_amount;

        case (r_state)
            ST_IDLE: begin
                if (bus.coin_valid) begin
                    if (w_coin_fits) begin
                        w_credit_nxt = w_sum[c_CREDIT_W-1:0];
                        w_state_nxt  = ST_CREDIT;
                    end else begin
                        w_coin_reject_nxt = 1'b1;
                    end
                end
            end

            // Priority: cancel > valid key > coin > inactivity timeout.
            ST_CREDIT: begin
                if (bus.cancel) begin
                    w_state_nxt         = ST_REFUND;
                    w_refund_amount_nxt = r_credit;
                    w_coin_reject_nxt   = bus.coin_valid;
                end else if (w_key_ok) begin
                    w_item_nxt        = bus.key_code;
                    w_state_nxt       = ST_REQUEST;
                    w_coin_reject_nxt = bus.coin_valid;
                end else if (bus.coin_valid && w_coin_fits) begin
                    w_credit_nxt = w_sum[c_CREDIT_W-1:0];
                end else if (w_timeout_expired) begin
                    w_state_nxt         = ST_REFUND;
                    w_refund_amount_nxt = r_credit;
                    w_coin_reject_nxt   = bus.coin_valid;
                end else begin
                    w_coin_reject_nxt = bus.coin_valid;
                end
            end

            ST_REQUEST: begin
                w_coin_reject_nxt = bus.coin_valid;
                if (bus.vend_ack) begin
                    w_state_nxt         = ST_REFUND;
                    w_refund_amount_nxt = bus.vend_balance;
                end
            end

            ST_REFUND: begin
                w_coin_reject_nxt   = bus.coin_valid;
                w_credit_nxt        = '0;
                w_item_nxt          = '0;
                w_refund_amount_nxt = '0;
                w_state_nxt         = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.deposited_amount = r_credit;
    assign bus.item_code        = r_item;
    assign bus.vend_req         = (r_state == ST_REQUEST);
    assign bus.coin_reject      = r_coin_reject;
    assign bus.refund_valid     = (r_state == ST_REFUND);
    assign bus.refund_amount    = r_refund_amount;

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_credit_collector
// Description : Self-checking bench for coin_credit_collector. A table of
//               single-cycle stimulus records with hand-computed outputs,
//               plus directed sequences for reset, mid-request reset and
//               the inactivity timeout (COIN_CREDIT_TIMEOUT_EN) or the
//               indefinite credit hold (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_credit_collector;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    coin_credit_collector_if bus_if();

    coin_credit_collector #(
        .MAX_CREDIT     (8'd250),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [1:0] ct;
        logic       kv;
        logic [3:0] kc;
        logic       cn;
        logic       va;
        logic [7:0] vb;
        logic [7:0] e_dep;
        logic [3:0] e_item;
        logic       e_vr;
        logic       e_rej;
        logic       e_rv;
        logic [7:0] e_ra;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.coin_valid   = 1'b0;
        bus_if.coin_type    = 2'b00;
        bus_if.key_valid    = 1'b0;
        bus_if.key_code     = 4'd0;
        bus_if.cancel       = 1'b0;
        bus_if.vend_ack     = 1'b0;
        bus_if.vend_balance = 8'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        bus_if.coin_valid = 1'b1;
        bus_if.coin_type  = t;
        tick();
        idle_inputs();
    endtask

    task automatic check_all_zero(input string name, input int idx);
        check({name, ".dep"},  idx, bus_if.deposited_amount, 0);
        check({name, ".item"}, idx, bus_if.item_code, 0);
        check({name, ".vr"},   idx, bus_if.vend_req, 0);
        check({name, ".rej"},  idx, bus_if.coin_reject, 0);
        check({name, ".rv"},   idx, bus_if.refund_valid, 0);
        check({name, ".ra"},   idx, bus_if.refund_amount, 0);
    endtask

    initial begin
        int first_refund;
        n_cmp = 0;
        n_err = 0;
        idle_inputs();

        // coin type: 0=5 1=10 2=20 3=50
        //                cv ct    kv kc     cn va vb      dep     item   vr rej rv ra
        vecs.push_back('{1, 2'd3, 0, 4'd0,  0, 0, 8'd0,  8'd50,  4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd3, 0, 4'd0,  0, 0, 8'd0,  8'd100, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd2, 0, 4'd0,  0, 0, 8'd0,  8'd120, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 1, 4'd3,  0, 0, 8'd0,  8'd120, 4'd3,  1, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd0, 0, 4'd0,  1, 0, 8'd0,  8'd120, 4'd3,  1, 1, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 1, 8'd70, 8'd120, 4'd3,  0, 0, 1, 8'd70});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd0,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 1, 4'd5,  1, 1, 8'd9,  8'd0,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd3, 0, 4'd0,  0, 0, 8'd0,  8'd50,  4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd3, 0, 4'd0,  0, 0, 8'd0,  8'd100, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd3, 0, 4'd0,  0, 0, 8'd0,  8'd150, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd3, 0, 4'd0,  0, 0, 8'd0,  8'd200, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd2, 0, 4'd0,  0, 0, 8'd0,  8'd220, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd2, 0, 4'd0,  0, 0, 8'd0,  8'd240, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd2, 0, 4'd0,  0, 0, 8'd0,  8'd240, 4'd0,  0, 1, 0, 8'd0});
        vecs.push_back('{1, 2'd1, 0, 4'd0,  0, 0, 8'd0,  8'd250, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd250, 4'd0,  0, 1, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 1, 4'd12, 0, 0, 8'd0,  8'd250, 4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd0, 1, 4'd0,  0, 0, 8'd0,  8'd250, 4'd0,  0, 1, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  1, 0, 8'd0,  8'd250, 4'd0,  0, 0, 1, 8'd250});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd0,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd2, 0, 4'd0,  0, 0, 8'd0,  8'd20,  4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd1, 0, 4'd0,  0, 0, 8'd0,  8'd30,  4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd0, 1, 4'd4,  1, 0, 8'd0,  8'd30,  4'd0,  0, 1, 1, 8'd30});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd0,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd5,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd0, 1, 4'd10, 0, 0, 8'd0,  8'd5,   4'd10, 1, 1, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 1, 8'd0,  8'd5,   4'd10, 0, 0, 1, 8'd0});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd0,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{1, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd5,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 1, 4'd11, 0, 0, 8'd0,  8'd5,   4'd0,  0, 0, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 1, 4'd1,  0, 0, 8'd0,  8'd5,   4'd1,  1, 0, 0, 8'd0});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 1, 8'd5,  8'd5,   4'd1,  0, 0, 1, 8'd5});
        vecs.push_back('{0, 2'd0, 0, 4'd0,  0, 0, 8'd0,  8'd0,   4'd0,  0, 0, 0, 8'd0});

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset", 0);
        reset = 1'b0;
        tick();
        check_all_zero("post_reset", 0);

        // Table-driven single-cycle vectors
        foreach (vecs[i]) begin
            bus_if.coin_valid   = vecs[i].cv;
            bus_if.coin_type    = vecs[i].ct;
            bus_if.key_valid    = vecs[i].kv;
            bus_if.key_code     = vecs[i].kc;
            bus_if.cancel       = vecs[i].cn;
            bus_if.vend_ack     = vecs[i].va;
            bus_if.vend_balance = vecs[i].vb;
            tick();
            idle_inputs();
            check("vec.dep",  i, bus_if.deposited_amount, vecs[i].e_dep);
            check("vec.item", i, bus_if.item_code,        vecs[i].e_item);
            check("vec.vr",   i, bus_if.vend_req,         vecs[i].e_vr);
            check("vec.rej",  i, bus_if.coin_reject,      vecs[i].e_rej);
            check("vec.rv",   i, bus_if.refund_valid,     vecs[i].e_rv);
            if (vecs[i].e_rv)
                check("vec.ra", i, bus_if.refund_amount, vecs[i].e_ra);
        end

        // Reset in the middle of a request: everything clears, no refund
        coin(2'd3);
        bus_if.key_valid = 1'b1;
        bus_if.key_code  = 4'd2;
        tick();
        idle_inputs();
        check("midreq.vr_before", 0, bus_if.vend_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreq.async", 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all_zero("midreq.after", k);
        end

        // Inactivity behaviour with a single 10-unit coin
        coin(2'd1);
        check("idle.dep_start", 0, bus_if.deposited_amount, 10);
`ifdef COIN_CREDIT_TIMEOUT_EN
        first_refund = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus_if.refund_valid && first_refund < 0) begin
                first_refund = k;
                check("timeout.ra", k, bus_if.refund_amount, 10);
            end
        end
        check("timeout.cycle", 0, first_refund, 8);
`else
        first_refund = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bus_if.refund_valid) first_refund++;
            if (bus_if.deposited_amount !== 8'd10)
                check("hold.dep", k, bus_if.deposited_amount, 10);
        end
        check("hold.refunds", 0, first_refund, 0);
        check("hold.dep_end", 0, bus_if.deposited_amount, 10);
        bus_if.cancel = 1'b1;
        tick();
        idle_inputs();
        check("hold.cancel_rv", 0, bus_if.refund_valid, 1);
        check("hold.cancel_ra", 0, bus_if.refund_amount, 10);
`endif
        tick();
        tick();
        check_all_zero("final", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
